mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port, variable-latency memory bus between the pipeline's instruction-fetch port and its MEM-stage data port. Sits between the PMIPS pipelined core (IF and MEM stages) and the unified instruction/data memory. Serializes accesses, raises stall signals that freeze the pipeline while an access is outstanding, returns registered read data, and bounds every access with a timeout.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_timeout.sv | 31 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
// Holds the FSM state encoding and default bus widths.
package mem_arbiter_pkg;

   localparam int AW_DEF      = 16;
   localparam int DW_DEF      = 17;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Arbiter bus bundle: fetch port, data port, memory port.
// slave = arbiter view, master = core/memory view.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 17
);
   logic          ireq;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] irdata;
   logic          iready;
   logic          istall;

   logic          dread;
   logic          dwrite;
   logic [AW-1:0] daddr;
   logic [15:0]   dwdata;
   logic [15:0]   drdata;
   logic          dready;
   logic          dstall;

   logic [AW-1:0] maddr;
   logic [DW-1:0] mwdata;
   logic          mreq;
   logic          mwe;
   logic          mack;
   logic [DW-1:0] mrdata;
   logic          merror;

   modport slave (
      input  ireq, iaddr,
      input  dread, dwrite, daddr, dwdata,
      input  mack, mrdata,
      output irdata, iready, istall,
      output drdata, dready, dstall,
      output maddr, mwdata, mreq, mwe,
      output merror
   );

   modport master (
      output ireq, iaddr,
      output dread, dwrite, daddr, dwdata,
      output mack, mrdata,
      input  irdata, iready, istall,
      input  drdata, dready, dstall,
      input  maddr, mwdata, mreq, mwe,
      input  merror
   );
endinterface

// File: rtl/mem_arbiter_timeout.sv
// arb_timeout: 8-bit access watchdog (clear, count, expire).
// Ports: clock, reset, clear_i, en_i, expired_o.
module arb_timeout #(
   parameter int LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   localparam logic [7:0] LIM = 8'(LIMIT);

   logic [7:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == LIM);

   // Saturate at the limit so an idle arbiter never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = 8'd0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a shared variable-latency memory.
// Ports: clock, reset, bus (fetch, data and memory sides).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   arb_state_e    state_q, state_d;

   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [DW-1:0] irdata_q, irdata_d;
   logic [15:0]   drdata_q, drdata_d;
   logic          iready_q, iready_d;
   logic          dready_q, dready_d;
   logic          merror_q, merror_d;

   logic          d_elig, i_elig;
   logic          grant_d, grant_i;
   logic          busy, done, tmo_exp;
   logic [DW-1:0] rdata;

   // A port is blind during its own ready pulse: the
   // request still high then belongs to the finished access.
   assign d_elig = (bus.dread | bus.dwrite) & ~dready_q;
   assign i_elig = bus.ireq & ~iready_q;

   assign busy  = (state_q != IDLE);
   assign done  = busy & (bus.mack | tmo_exp);
   // mack wins over an expiry in the same cycle.
   assign rdata = bus.mack ? bus.mrdata : '0;

   arb_timeout #(.LIMIT(TIMEOUT)) u_tmo (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (grant_d | grant_i),
      .en_i      (busy),
      .expired_o (tmo_exp)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      grant_i = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_elig) begin
               state_d = DACC;
               grant_d = 1'b1;
            end else if (i_elig) begin
               state_d = IACC;
               grant_i = 1'b1;
            end
         end
         IACC, DACC: begin
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode straight from state so reset drops them
   // asynchronously.
   always_comb begin
      bus.mreq = busy;
      bus.mwe  = (state_q == DACC) & we_q;
   end

   always_comb begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      merror_d = merror_q;
      iready_d = (state_q == IACC) & done;
      dready_d = (state_q == DACC) & done;
      if (grant_d) begin
         addr_d  = bus.daddr;
         wdata_d = bus.dwdata;
         we_d    = bus.dwrite;
      end
      if (grant_i) begin
         addr_d = bus.iaddr;
         we_d   = 1'b0;
      end
      if ((state_q == IACC) && done)
         irdata_d = rdata;
      if ((state_q == DACC) && done && !we_q)
         drdata_d = rdata[15:0];
      if (done && !bus.mack)
         merror_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         iready_q <= 1'b0;
         dready_q <= 1'b0;
         merror_q <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         iready_q <= iready_d;
         dready_q <= dready_d;
         merror_q <= merror_d;
      end
   end

   assign bus.maddr  = addr_q;
   assign bus.mwdata = {{(DW-16){1'b0}}, wdata_q};
   assign bus.irdata = irdata_q;
   assign bus.drdata = drdata_q;
   assign bus.iready = iready_q;
   assign bus.dready = dready_q;
   assign bus.merror = merror_q;
   assign bus.istall = bus.ireq & ~iready_q;
   assign bus.dstall = (bus.dread | bus.dwrite) & ~dready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Inputs change at negedge, outputs sampled 1ns later.
module tb_mem_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if #(.AW(16), .DW(17)) bus ();

   mem_arbiter #(.AW(16), .DW(17), .TIMEOUT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      bus.ireq   = 1'b0;
      bus.iaddr  = '0;
      bus.dread  = 1'b0;
      bus.dwrite = 1'b0;
      bus.daddr  = '0;
      bus.dwdata = '0;
      bus.mack   = 1'b0;
      bus.mrdata = '0;

      // Reset values
      step();
      #1;
      check("rst_mreq", 32'(bus.mreq), 0);
      check("rst_mwe", 32'(bus.mwe), 0);
      check("rst_iready", 32'(bus.iready), 0);
      check("rst_dready", 32'(bus.dready), 0);
      check("rst_merror", 32'(bus.merror), 0);
      check("rst_irdata", 32'(bus.irdata), 0);
      check("rst_drdata", 32'(bus.drdata), 0);
      check("rst_maddr", 32'(bus.maddr), 0);
      check("rst_mwdata", 32'(bus.mwdata), 0);
      step();
      reset = 1'b0;

      // Single fetch, mack one cycle after mreq
      step();
      bus.ireq  = 1'b1;
      bus.iaddr = 16'h0010;
      #1;
      check("f_c0_stall", 32'(bus.istall), 1);
      check("f_c0_mreq", 32'(bus.mreq), 0);
      step(); #1;
      check("f_c1_mreq", 32'(bus.mreq), 1);
      check("f_c1_maddr", 32'(bus.maddr), 32'h10);
      check("f_c1_mwe", 32'(bus.mwe), 0);
      check("f_c1_stall", 32'(bus.istall), 1);
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h1ABCD;
      #1;
      check("f_c2_stall", 32'(bus.istall), 1);
      check("f_c2_iready", 32'(bus.iready), 0);
      step();
      bus.mack = 1'b0;
      #1;
      check("f_c3_iready", 32'(bus.iready), 1);
      check("f_c3_irdata", 32'(bus.irdata), 32'h1ABCD);
      check("f_c3_stall", 32'(bus.istall), 0);
      check("f_c3_mreq", 32'(bus.mreq), 0);
      bus.ireq = 1'b0;
      step(); #1;
      check("f_c4_iready", 32'(bus.iready), 0);
      check("f_c4_mreq", 32'(bus.mreq), 0);

      // Store, zero-wait
      step();
      bus.dwrite = 1'b1;
      bus.daddr  = 16'h0040;
      bus.dwdata = 16'h1234;
      #1;
      check("s_c0_stall", 32'(bus.dstall), 1);
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h1FFFF;
      #1;
      check("s_c1_mreq", 32'(bus.mreq), 1);
      check("s_c1_mwe", 32'(bus.mwe), 1);
      check("s_c1_maddr", 32'(bus.maddr), 32'h40);
      check("s_c1_mwdata", 32'(bus.mwdata), 32'h01234);
      step();
      bus.mack = 1'b0;
      #1;
      check("s_c2_dready", 32'(bus.dready), 1);
      check("s_c2_stall", 32'(bus.dstall), 0);
      check("s_c2_drdata", 32'(bus.drdata), 0);
      check("s_c2_mreq", 32'(bus.mreq), 0);
      bus.dwrite = 1'b0;

      // Load back, zero-wait
      step();
      bus.dread = 1'b1;
      #1;
      check("l_c0_dready", 32'(bus.dready), 0);
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h01234;
      #1;
      check("l_c1_mreq", 32'(bus.mreq), 1);
      check("l_c1_mwe", 32'(bus.mwe), 0);
      check("l_c1_maddr", 32'(bus.maddr), 32'h40);
      step();
      bus.mack = 1'b0;
      #1;
      check("l_c2_dready", 32'(bus.dready), 1);
      check("l_c2_drdata", 32'(bus.drdata), 32'h1234);
      bus.dread = 1'b0;
      step();

      // Simultaneous ireq + dread: data first
      step();
      bus.ireq  = 1'b1;
      bus.iaddr = 16'h0020;
      bus.dread = 1'b1;
      bus.daddr = 16'h0044;
      #1;
      check("b_c0_mreq", 32'(bus.mreq), 0);
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h00077;
      #1;
      check("b_c1_mreq", 32'(bus.mreq), 1);
      check("b_c1_maddr", 32'(bus.maddr), 32'h44);
      check("b_c1_istall", 32'(bus.istall), 1);
      step();
      bus.mack = 1'b0;
      #1;
      check("b_c2_dready", 32'(bus.dready), 1);
      check("b_c2_drdata", 32'(bus.drdata), 32'h77);
      check("b_c2_mreq", 32'(bus.mreq), 0);
      check("b_c2_iready", 32'(bus.iready), 0);
      bus.dread = 1'b0;
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h10101;
      #1;
      check("b_c3_mreq", 32'(bus.mreq), 1);
      check("b_c3_maddr", 32'(bus.maddr), 32'h20);
      check("b_c3_dready", 32'(bus.dready), 0);
      step();
      bus.mack = 1'b0;
      #1;
      check("b_c4_iready", 32'(bus.iready), 1);
      check("b_c4_irdata", 32'(bus.irdata), 32'h10101);
      check("b_c4_merror", 32'(bus.merror), 0);
      bus.ireq = 1'b0;
      step();

      // Memory never acks: timeout
      step();
      bus.dread = 1'b1;
      bus.daddr = 16'h0050;
      #1;
      for (int k = 1; k <= 16; k++) begin
         step(); #1;
         check($sformatf("t_c%0d_mreq", k), 32'(bus.mreq), 1);
         check($sformatf("t_c%0d_dready", k),
               32'(bus.dready), 0);
      end
      step(); #1;
      check("t_c17_dready", 32'(bus.dready), 1);
      check("t_c17_drdata", 32'(bus.drdata), 0);
      check("t_c17_merror", 32'(bus.merror), 1);
      check("t_c17_mreq", 32'(bus.mreq), 0);
      bus.dread = 1'b0;
      step();
      step(); #1;
      check("t_sticky", 32'(bus.merror), 1);

      // mack on the exact expiry cycle
      do_reset();
      step();
      bus.dread = 1'b1;
      bus.daddr = 16'h0060;
      #1;
      for (int k = 1; k <= 15; k++) begin
         step(); #1;
      end
      check("e_c15_mreq", 32'(bus.mreq), 1);
      check("e_c15_dready", 32'(bus.dready), 0);
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h00055;
      #1;
      check("e_c16_mreq", 32'(bus.mreq), 1);
      step();
      bus.mack = 1'b0;
      #1;
      check("e_c17_dready", 32'(bus.dready), 1);
      check("e_c17_drdata", 32'(bus.drdata), 32'h55);
      check("e_c17_merror", 32'(bus.merror), 0);
      bus.dread = 1'b0;
      step();

      // Reset in the middle of a data wait
      step();
      bus.dwrite = 1'b1;
      bus.daddr  = 16'h0070;
      bus.dwdata = 16'hBEEF;
      step(); #1;
      check("r_c1_mwe", 32'(bus.mwe), 1);
      step(); #1;
      check("r_c2_mreq", 32'(bus.mreq), 1);
      reset = 1'b1;
      #1;
      check("r_async_mreq", 32'(bus.mreq), 0);
      check("r_async_mwe", 32'(bus.mwe), 0);
      step();
      reset      = 1'b0;
      bus.dwrite = 1'b0;
      #1;
      check("r_no_dready", 32'(bus.dready), 0);
      step(); #1;
      check("r_no_dready2", 32'(bus.dready), 0);
      check("r_idle_mreq", 32'(bus.mreq), 0);

      step();
      bus.ireq  = 1'b1;
      bus.iaddr = 16'h0080;
      step();
      bus.mack   = 1'b1;
      bus.mrdata = 17'h12345;
      #1;
      check("r_f_mreq", 32'(bus.mreq), 1);
      check("r_f_maddr", 32'(bus.maddr), 32'h80);
      step();
      bus.mack = 1'b0;
      #1;
      check("r_f_iready", 32'(bus.iready), 1);
      check("r_f_irdata", 32'(bus.irdata), 32'h12345);
      bus.ireq = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
